// File: rtl/dma_ahb_pkg.sv
// Shared constants for the DMA AHB engine and its CSR block: register offsets,
// CTRL/START bit positions and the AHB HTRANS/HSIZE encodings.
package dma_ahb_pkg;

  localparam logic [31:0] OFF_VERSION = 32'h00;
  localparam logic [31:0] OFF_CTRL    = 32'h10;
  localparam logic [31:0] OFF_START   = 32'h14;
  localparam logic [31:0] OFF_SRC     = 32'h20;
  localparam logic [31:0] OFF_DST     = 32'h24;
  localparam logic [31:0] OFF_BNUM    = 32'h28;
  localparam logic [31:0] OFF_BURST   = 32'h2C;

  localparam int CTRL_EN_BIT    = 31;
  localparam int CTRL_IP_BIT    = 1;
  localparam int CTRL_IE_BIT    = 0;
  localparam int START_GO_BIT   = 0;
  localparam int START_BUSY_BIT = 31;
  localparam int START_DONE_BIT = 30;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

endpackage

// File: rtl/dma_ahb_csr_if.sv
// AHB-Lite slave-port bundle of the DMA CSR block.
interface dma_ahb_csr_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic [1:0]  HRESP;
  logic        HREADYout;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HRDATA, HRESP, HREADYout
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HRDATA, HRESP, HREADYout
  );
endinterface

// File: rtl/dma_ahb_csr.sv
// AHB-Lite register file programming the DMA engine; GO self-clears on DONE.
// Define DMA_CSR_IRQ_EN to build the IE/IP bits and the IRQ output.
module dma_ahb_csr
  import dma_ahb_pkg::*;
#(
  parameter logic [31:0] P_VERSION = 32'h2014_0429,
  parameter int          P_OFF_WID = 8
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  dma_ahb_csr_if.slave        ahb,
  output logic                DMA_EN,
  output logic                DMA_GO,
  input  logic                DMA_BUSY,
  input  logic                DMA_DONE,
  output logic [31:0]         DMA_SRC,
  output logic [31:0]         DMA_DST,
  output logic [15:0]         DMA_BNUM,
  output logic [4:0]          DMA_BURST,
  output logic                IRQ
);

  function automatic logic is_off(input logic [P_OFF_WID-1:0] off, input logic [31:0] target);
    return 32'(off) == target;
  endfunction

  logic                 ap_valid, ap_write, ap_read;
  logic [P_OFF_WID-1:0] ap_off;
  logic                 wr_pend, wr_take;
  logic [P_OFF_WID-1:0] wr_off;
  logic                 unused_ok;

  assign ap_valid  = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];
  assign ap_write  = ap_valid & ahb.HWRITE & (ahb.HSIZE == HSIZE_WORD);
  assign ap_read   = ap_valid & ~ahb.HWRITE;
  assign ap_off    = {ahb.HADDR[P_OFF_WID-1:2], 2'b00};
  assign wr_take   = wr_pend & ahb.HREADY;
  assign unused_ok = ^{ahb.HADDR[31:P_OFF_WID], ahb.HADDR[1:0], ahb.HTRANS[0]};

  logic        en, go, done_d;
  logic [31:0] src, dst;
  logic [15:0] bnum;
  logic [4:0]  burst;
  logic        ie, ip;
  logic        nxt_en, nxt_go;
  logic [31:0] nxt_src, nxt_dst;
  logic [15:0] nxt_bnum;
  logic [4:0]  nxt_burst;
  logic        done_rise, go_ok;
  logic [31:0] wd, rd_val;

  assign wd        = ahb.HWDATA;
  assign done_rise = DMA_DONE & ~done_d;
  assign go_ok     = en & (|bnum) & (|burst) & ~DMA_BUSY & ~DMA_DONE;

`ifdef DMA_CSR_IRQ_EN
  logic nxt_ie, nxt_ip;
`else
  assign ie = 1'b0;
  assign ip = 1'b0;
`endif

  always_comb begin
    nxt_en    = en;
    nxt_go    = go;
    nxt_src   = src;
    nxt_dst   = dst;
    nxt_bnum  = bnum;
    nxt_burst = burst;
`ifdef DMA_CSR_IRQ_EN
    nxt_ie    = ie;
    nxt_ip    = ip;
`endif
    if (wr_take) begin
      if (is_off(wr_off, OFF_CTRL)) begin
        nxt_en = wd[CTRL_EN_BIT];
        if (!wd[CTRL_EN_BIT]) nxt_go = 1'b0;
`ifdef DMA_CSR_IRQ_EN
        nxt_ie = wd[CTRL_IE_BIT];
        if (wd[CTRL_IP_BIT]) nxt_ip = 1'b0;
`endif
      end
      if (is_off(wr_off, OFF_START)) begin
        if (!wd[START_GO_BIT]) nxt_go = 1'b0;
        else if (go_ok)        nxt_go = 1'b1;
      end
      if (!DMA_BUSY) begin
        if (is_off(wr_off, OFF_SRC))   nxt_src   = wd;
        if (is_off(wr_off, OFF_DST))   nxt_dst   = wd;
        if (is_off(wr_off, OFF_BNUM))  nxt_bnum  = wd[15:0];
        if (is_off(wr_off, OFF_BURST)) nxt_burst = wd[4:0];
      end
    end
    // Completion is applied after the bus write so that it beats a same-cycle W1C.
    if (done_rise) begin
      nxt_go = 1'b0;
`ifdef DMA_CSR_IRQ_EN
      if (ie) nxt_ip = 1'b1;
`endif
    end
  end

  // Reads decode the post-update values, which forwards a write still in its data phase.
  always_comb begin
    rd_val = 32'h0;
    if (is_off(ap_off, OFF_VERSION)) rd_val = P_VERSION;
    if (is_off(ap_off, OFF_CTRL)) begin
      rd_val[CTRL_EN_BIT] = nxt_en;
`ifdef DMA_CSR_IRQ_EN
      rd_val[CTRL_IP_BIT] = nxt_ip;
      rd_val[CTRL_IE_BIT] = nxt_ie;
`endif
    end
    if (is_off(ap_off, OFF_START)) begin
      rd_val[START_GO_BIT]   = nxt_go;
      rd_val[START_BUSY_BIT] = DMA_BUSY;
      rd_val[START_DONE_BIT] = DMA_DONE;
    end
    if (is_off(ap_off, OFF_SRC))   rd_val = nxt_src;
    if (is_off(ap_off, OFF_DST))   rd_val = nxt_dst;
    if (is_off(ap_off, OFF_BNUM))  rd_val = {16'h0, nxt_bnum};
    if (is_off(ap_off, OFF_BURST)) rd_val = {27'h0, nxt_burst};
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_pend    <= 1'b0;
      wr_off     <= '0;
      en         <= 1'b0;
      go         <= 1'b0;
      src        <= 32'h0;
      dst        <= 32'h0;
      bnum       <= 16'h0;
      burst      <= 5'h0;
      done_d     <= 1'b0;
      ahb.HRDATA <= 32'h0;
    end else begin
      if (ahb.HREADY) begin
        wr_pend <= ap_write;
        wr_off  <= ap_off;
      end
      en     <= nxt_en;
      go     <= nxt_go;
      src    <= nxt_src;
      dst    <= nxt_dst;
      bnum   <= nxt_bnum;
      burst  <= nxt_burst;
      done_d <= DMA_DONE;
      if (ap_read) ahb.HRDATA <= rd_val;
    end
  end

`ifdef DMA_CSR_IRQ_EN
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ie <= 1'b0;
      ip <= 1'b0;
    end else begin
      ie <= nxt_ie;
      ip <= nxt_ip;
    end
  end
`endif

  assign ahb.HRESP     = 2'b00;
  assign ahb.HREADYout = 1'b1;
  assign DMA_EN        = en;
  assign DMA_GO        = go;
  assign DMA_SRC       = src;
  assign DMA_DST       = dst;
  assign DMA_BNUM      = bnum;
  assign DMA_BURST     = burst;
  assign IRQ           = ip & ie;

endmodule

// File: tb/tb_dma_ahb_csr.sv
// Bench for dma_ahb_csr: directed scenarios plus random AHB traffic against a
// register-level reference model; read data goes through an expected queue.
module tb_dma_ahb_csr;
  import dma_ahb_pkg::*;

  localparam logic [31:0] VERSION = 32'h2014_0429;
`ifdef DMA_CSR_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        DMA_EN, DMA_GO, DMA_BUSY, DMA_DONE, IRQ;
  logic [31:0] DMA_SRC, DMA_DST;
  logic [15:0] DMA_BNUM;
  logic [4:0]  DMA_BURST;

  dma_ahb_csr_if bus();

  dma_ahb_csr dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .ahb(bus.slave),
    .DMA_EN(DMA_EN), .DMA_GO(DMA_GO), .DMA_BUSY(DMA_BUSY), .DMA_DONE(DMA_DONE),
    .DMA_SRC(DMA_SRC), .DMA_DST(DMA_DST), .DMA_BNUM(DMA_BNUM), .DMA_BURST(DMA_BURST),
    .IRQ(IRQ)
  );

  // clock / reset
  always #5 HCLK = ~HCLK;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  // reference model: register contents after the most recent clock edge
  logic        m_en, m_go, m_ie, m_ip, m_done_d;
  logic [31:0] m_src, m_dst;
  logic [15:0] m_bnum;
  logic [4:0]  m_burst;
  logic        pend_v;
  logic [7:0]  pend_off;
  logic [31:0] pend_data;
  logic        busy_v = 1'b0;
  logic        done_v = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor: compares HRDATA in every read data phase
  logic rd_dp;
  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)        rd_dp <= 1'b0;
    else if (bus.HREADY) rd_dp <= bus.HSEL & bus.HTRANS[1] & ~bus.HWRITE;
  end

  always @(negedge HCLK) begin
    if (rd_dp) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL hrdata_unexpected: got %h expected no read", bus.HRDATA);
      end else begin
        chk("hrdata", bus.HRDATA, exp_q.pop_front());
      end
    end
  end

  task automatic model_reset();
    m_en = 0; m_go = 0; m_ie = 0; m_ip = 0; m_done_d = 0;
    m_src = 0; m_dst = 0; m_bnum = 0; m_burst = 0;
    pend_v = 0; pend_off = 0; pend_data = 0;
    exp_q.delete();
  endtask

  function automatic logic [31:0] model_read(input logic [7:0] off);
    case (off)
      8'h00:   return VERSION;
      8'h10:   return {m_en, 29'h0, m_ip, m_ie};
      8'h14:   return {busy_v, done_v, 29'h0, m_go};
      8'h20:   return m_src;
      8'h24:   return m_dst;
      8'h28:   return {16'h0, m_bnum};
      8'h2C:   return {27'h0, m_burst};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_write(input logic [7:0] off, input logic [31:0] d);
    case (off)
      8'h10: begin
        m_en = d[31];
        if (!d[31]) m_go = 0;
        if (IRQ_ON) begin
          m_ie = d[0];
          if (d[1]) m_ip = 0;
        end
      end
      8'h14: begin
        if (!d[0]) m_go = 0;
        else if (m_en && m_bnum != 0 && m_burst != 0 && !busy_v && !done_v) m_go = 1;
      end
      8'h20: if (!busy_v) m_src = d;
      8'h24: if (!busy_v) m_dst = d;
      8'h28: if (!busy_v) m_bnum = d[15:0];
      8'h2C: if (!busy_v) m_burst = d[4:0];
      default: ;
    endcase
  endtask

  task automatic check_pins();
    chk("DMA_EN", 32'(DMA_EN), 32'(m_en));
    chk("DMA_GO", 32'(DMA_GO), 32'(m_go));
    chk("DMA_SRC", DMA_SRC, m_src);
    chk("DMA_DST", DMA_DST, m_dst);
    chk("DMA_BNUM", 32'(DMA_BNUM), 32'(m_bnum));
    chk("DMA_BURST", 32'(DMA_BURST), 32'(m_burst));
    chk("IRQ", 32'(IRQ), 32'(m_ip & m_ie));
    chk("HREADYout", 32'(bus.HREADYout), 32'h1);
    chk("HRESP", 32'(bus.HRESP), 32'h0);
  endtask

  // driver: one bus cycle; address phase of this op, data phase of the previous one
  task automatic step(input bit act, input bit wr, input logic [7:0] off,
                      input logic [31:0] wdata, input logic [2:0] size);
    logic [31:0] r;
    logic        old_ie;
    r = $urandom;
    bus.HWDATA = pend_data;
    bus.HSEL   = act;
    bus.HTRANS = act ? HTRANS_NONSEQ : HTRANS_IDLE;
    bus.HWRITE = wr;
    bus.HSIZE  = size;
    bus.HADDR  = {r[31:8], off[7:2], r[1:0]};
    bus.HREADY = 1'b1;
    DMA_BUSY   = busy_v;
    DMA_DONE   = done_v;
    old_ie = m_ie;
    if (pend_v) model_write(pend_off, pend_data);
    if (done_v && !m_done_d) begin
      m_go = 0;
      if (old_ie) m_ip = 1;
    end
    m_done_d = done_v;
    if (act && !wr) exp_q.push_back(model_read(off));
    pend_v    = act && wr && (size == HSIZE_WORD);
    pend_off  = off;
    pend_data = wdata;
    @(posedge HCLK);
    #1;
    check_pins();
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d);
    step(1'b1, 1'b1, off, d, HSIZE_WORD);
  endtask

  task automatic rd(input logic [7:0] off);
    step(1'b1, 1'b0, off, 32'h0, HSIZE_WORD);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 32'h0, HSIZE_WORD);
  endtask

  task automatic program_and_start();
    wr(8'h20, 32'h1000);
    wr(8'h24, 32'h2000);
    wr(8'h28, 32'd64);
    wr(8'h2C, 32'd4);
    wr(8'h10, 32'h8000_0001);
    wr(8'h14, 32'h1);
    idle(1);
  endtask

  logic [7:0] offs [10] = '{8'h00, 8'h10, 8'h14, 8'h20, 8'h24, 8'h28, 8'h2C, 8'h04, 8'h3C, 8'hFC};

  initial begin
    bus.HSEL = 0; bus.HTRANS = HTRANS_IDLE; bus.HWRITE = 0; bus.HSIZE = HSIZE_WORD;
    bus.HADDR = 0; bus.HWDATA = 0; bus.HREADY = 1;
    DMA_BUSY = 0; DMA_DONE = 0;
    model_reset();
    repeat (2) @(posedge HCLK);
    #1;
    check_pins();
    chk("reset_hrdata", bus.HRDATA, 32'h0);
    HRESETn = 1'b1;

    // reset values
    rd(8'h00); rd(8'h10); rd(8'h14); rd(8'h20);
    idle(1);

    // normal transfer with completion and interrupt
    program_and_start();
    chk("go_started", 32'(DMA_GO), 32'h1);
    busy_v = 1; idle(2);
    busy_v = 0; done_v = 1; idle(1);
    chk("go_autoclear", 32'(DMA_GO), 32'h0);
    chk("irq_on_done", 32'(IRQ), 32'(IRQ_ON));
    done_v = 0; idle(1);
    wr(8'h10, 32'h8000_0003); idle(1);
    chk("irq_w1c", 32'(IRQ), 32'h0);

    // GO refused with BNUM==0, then with BURST==0
    wr(8'h28, 32'h0); wr(8'h14, 32'h1); idle(1);
    chk("go_bnum0", 32'(DMA_GO), 32'h0);
    wr(8'h28, 32'd64); wr(8'h2C, 32'h0); wr(8'h14, 32'h1); idle(1);
    chk("go_burst0", 32'(DMA_GO), 32'h0);
    wr(8'h2C, 32'd4);

    // writes while busy
    busy_v = 1;
    wr(8'h20, 32'hDEAD); rd(8'h20); wr(8'h14, 32'h1); idle(1);
    chk("src_busy", DMA_SRC, 32'h1000);
    chk("go_busy", 32'(DMA_GO), 32'h0);
    busy_v = 0;

    // back-to-back write/read forwarding
    wr(8'h24, 32'h55AA_0000); rd(8'h24); idle(1);

    // completion in the same cycle as an IP W1C
    wr(8'h14, 32'h1); idle(1);
    wr(8'h10, 32'h8000_0003);
    done_v = 1; idle(1);
    chk("ip_set_wins", 32'(IRQ), 32'(IRQ_ON));
    rd(8'h10);
    done_v = 0; idle(1);
    wr(8'h10, 32'h8000_0003); idle(1);

    // EN=0 mid-transfer
    wr(8'h14, 32'h1); idle(1);
    busy_v = 1; idle(1);
    wr(8'h10, 32'h0); idle(1);
    chk("abort_en", 32'(DMA_EN), 32'h0);
    chk("abort_go", 32'(DMA_GO), 32'h0);
    busy_v = 0; idle(1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      int op;
      logic [7:0]  off;
      logic [31:0] d;
      logic [2:0]  sz;
      if ($urandom_range(0, 3) == 0) busy_v = ~busy_v;
      if ($urandom_range(0, 7) == 0) done_v = ~done_v;
      op  = $urandom_range(0, 9);
      off = offs[$urandom_range(0, 9)];
      d   = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
      if (off == 8'h10 && $urandom_range(0, 3) != 0) d[31] = 1'b1;
      sz  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 1)) : HSIZE_WORD;
      if (op < 2)      step(1'b0, 1'b0, off, 32'h0, HSIZE_WORD);
      else if (op < 6) step(1'b1, 1'b1, off, d, sz);
      else             step(1'b1, 1'b0, off, 32'h0, sz);
    end
    busy_v = 0; done_v = 0;
    idle(2);

    // asynchronous reset in the middle of a transfer
    program_and_start();
    busy_v = 1; idle(1);
    HRESETn = 1'b0;
    model_reset();
    busy_v = 0;
    #1;
    check_pins();
    chk("async_rst_hrdata", bus.HRDATA, 32'h0);
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    idle(1);
    rd(8'h14); idle(2);

    chk("exp_q_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_ahb_csr.md
# dma_ahb_csr

AHB-Lite slave register file that programs and monitors the DMA AHB master engine. It sits directly upstream of the DMA engine: software writes source, destination, byte count and burst length, then sets GO. The block drives the engine's DMA_* control inputs and consumes its BUSY/DONE status. GO is cleared automatically on completion, and an optional interrupt is raised.

## Interface
- P_VERSION, 32'h2014_0429, value returned by the VERSION register
- P_OFF_WID, 8, number of HADDR LSBs decoded (register window 256 B)

- HCLK  in  1  clock
- HRESETn  in  1  reset; one clock, asynchronous assert, active-low
- HSEL  in  1  slave select
- HADDR  in  32  address; only [P_OFF_WID-1:2] is decoded
- HTRANS  in  2  transfer type; a valid transfer has HTRANS[1]=1
- HWRITE  in  1  write transfer
- HSIZE  in  3  transfer size; only 3'b010 (word) is accepted
- HWDATA  in  32  write data
- HREADY  in  1  bus ready (HREADYin)
- HRDATA  out  32  read data
- HRESP  out  2  always 2'b00 (OKAY)
- HREADYout  out  1  always 1 (zero wait state)
- DMA_EN  out  1  engine enable
- DMA_GO  out  1  start request (level)
- DMA_BUSY  in  1  engine busy
- DMA_DONE  in  1  engine done; held until DMA_GO falls
- DMA_SRC, DMA_DST  out  32 each  byte addresses
- DMA_BNUM  out  16  bytes to move
- DMA_BURST  out  5  beats per burst (1/4/8/16; any other non-zero value gives INCR)
- IRQ  out  1  level interrupt

## Operation
Register map (word offsets; unused bits read 0; unmapped offsets read 0, and writes to them are dropped):
- 0x00 VERSION RO: P_VERSION.
- 0x10 CTRL: [31] EN RW; [1] IP W1C; [0] IE RW.
- 0x14 START: [0] GO RW; [31] BUSY RO (DMA_BUSY); [30] DONE RO (DMA_DONE).
- 0x20 SRC RW; 0x24 DST RW; 0x28 BNUM[15:0] RW; 0x2C BURST[4:0] RW.

Rules:
- A write is taken when HSEL&HREADY&HTRANS[1]&HWRITE&(HSIZE==3'b010). Non-word writes are dropped without error.
- SRC/DST/BNUM/BURST writes are dropped while DMA_BUSY=1.
- Writing GO=1 is dropped in any of these cases:
  - EN=0
  - BNUM==0
  - BURST==0
  - DMA_BUSY=1
  - DMA_DONE=1
- Writing GO=0 is always accepted.
- Completion is the rising edge of DMA_DONE (DMA_DONE=1 and done_d=0). On completion:
  - GO is cleared.
  - IP is set if IE=1.
- If a completion and a W1C to IP occur in the same cycle, set wins.
- A write of EN=0 clears GO in the same cycle. IP is unchanged. The engine aborts by its own rule.
- IRQ = IP & IE.
- DMA_EN = EN. DMA_GO = GO. The remaining DMA_* outputs are direct register outputs.

## Timing
- Reset: every register, HRDATA, DMA_* outputs, IRQ and done_d are 0; HREADYout=1; HRESP=2'b00.
- Read:
  - HRDATA is registered at the end of the address phase, so it is valid throughout the following data phase.
  - HRDATA holds its value otherwise.
- Write:
  - Address, valid flag and size check are latched in the address phase.
  - The register updates at the end of the data phase using HWDATA.
  - Outputs change 1 cycle after the data phase.
- Back-to-back write then read of the same offset: the read is forwarded. HRDATA takes HWDATA masked to the register's field width, with the W1C/RO rules applied.
- done_d is DMA_DONE delayed one cycle. GO falls 1 cycle after DMA_DONE rises, and IP rises in the same cycle as GO falls.

## Configuration
- DMA_CSR_IRQ_EN defined: IE, IP and IRQ are implemented as above.
- DMA_CSR_IRQ_EN undefined:
  - IE/IP flops are removed; CTRL[1:0] reads 0 and writes to them are ignored.
  - IRQ is tied to 0.
  - GO auto-clear still operates.

## Structure
- Shared package dma_ahb_pkg:
  - register offset constants (VERSION, CTRL, START, SRC, DST, BNUM, BURST)
  - CTRL/START bit-position constants
  - HTRANS/HSIZE encodings shared with the engine
- Single module; no sub-module.

## Test plan
- Reset, then read 0x00 -> HRDATA=32'h2014_0429. Read 0x10/0x14/0x20 -> 0.
- Write SRC=0x1000, DST=0x2000, BNUM=64, BURST=4, CTRL=0x8000_0001, START=1 -> DMA_GO=1. Model pulses BUSY then raises DONE -> GO=0 next cycle, IP=1, IRQ=1. Write CTRL=0x8000_0003 -> IP=0, IRQ=0.
- With BNUM=0, write START=1 -> DMA_GO stays 0.
- Same with BURST=0 -> DMA_GO stays 0.
- With DMA_BUSY=1, write SRC=0xDEAD -> SRC is unchanged. Write START=1 -> dropped.
- Write 0x24=0x55AA_0000 immediately followed by a read of 0x24 -> HRDATA=0x55AA_0000 in the read data phase.
- DONE rises in the same cycle as a W1C to IP -> IP=1.
- Write CTRL EN=0 mid-transfer -> DMA_EN=0 and DMA_GO=0 next cycle.
- Assert HRESETn=0 mid-transfer -> all outputs are 0 immediately.
